// File: rtl/mac_host_cfg_arb.sv
// mac_host_cfg_arb: two-requester arbiter and sequencer for the 10G MAC host
// configuration / MDIO interface. rq0 is the PCIe register path, rq1 the PHY
// init/poll engine. Handles config reads/writes, MIIM accesses with completion
// wait and timeout, and read-data return.
// Optional build macro MAC_HOST_CFG_STATS_EN adds saturating transaction and
// timeout counters on stat_xact_cnt / stat_timeout_cnt.
module mac_host_cfg_arb #(
  parameter int CFG_RD_LAT   = 2,
  parameter int MIIM_TIMEOUT = 65535
) (
  input  logic        mac_host_clk,
  input  logic        mac_host_reset,
  input  logic [1:0]  rq_valid,
  input  logic [1:0]  rq_miim_sel,
  input  logic [3:0]  rq_opcode,
  input  logic [19:0] rq_addr,
  input  logic [63:0] rq_wr_data,
  output logic [1:0]  rq_done,
  output logic [31:0] rq_rd_data,
  output logic        rq_err,
  output logic [1:0]  mac_host_opcode,
  output logic [9:0]  mac_host_addr,
  output logic [31:0] mac_host_wr_data,
  input  logic [31:0] mac_host_rd_data,
  output logic        mac_host_miim_sel,
  output logic        mac_host_req,
  input  logic        mac_host_miim_rdy
`ifdef MAC_HOST_CFG_STATS_EN
  ,
  output logic [15:0] stat_xact_cnt,
  output logic [15:0] stat_timeout_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    CFG_WAIT = 3'd2,
    MIIM_LO  = 3'd3,
    MIIM_HI  = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [15:0] TMO_LIMIT   = 16'(MIIM_TIMEOUT);
  localparam logic [15:0] CFG_LAST    = 16'(CFG_RD_LAT - 1);
  localparam logic [31:0] TMO_RD_DATA = 32'hFFFF_FFFF;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;       // requester currently owning the interface
  logic        prio_q, prio_d;     // requester favoured on the next contention
  logic [15:0] cnt_q, cnt_d;       // CFG_WAIT latency count / MIIM timeout count
  logic [1:0]  opcode_q, opcode_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        miim_q, miim_d;
  logic        req_q, req_d;
  logic [1:0]  done_q, done_d;
  logic [31:0] rd_q, rd_d;
  logic        err_q, err_d;

  logic        pick;
  logic        pick_miim;
  logic [1:0]  pick_opcode;
  logic [9:0]  pick_addr;
  logic [31:0] pick_wdata;
  logic [15:0] cnt_inc;
  logic        timeout_hit;
  logic [1:0]  done_vec;

  // Round-robin choice: contention goes to the favoured requester, otherwise
  // whichever one is asking.
  assign pick        = (rq_valid == 2'b11) ? prio_q : rq_valid[1];
  assign pick_miim   = pick ? rq_miim_sel[1]      : rq_miim_sel[0];
  assign pick_opcode = pick ? rq_opcode[3:2]      : rq_opcode[1:0];
  assign pick_addr   = pick ? rq_addr[19:10]      : rq_addr[9:0];
  assign pick_wdata  = pick ? rq_wr_data[63:32]   : rq_wr_data[31:0];

  // Timeout counter saturates rather than wrapping; the limit is checked on
  // the incremented value so the MIIM states last exactly MIIM_TIMEOUT cycles.
  assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign timeout_hit = (cnt_inc == TMO_LIMIT);
  assign done_vec    = gnt_q ? 2'b10 : 2'b01;

  // Next-state and registered-output decode for the access sequencer
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    prio_d   = prio_q;
    cnt_d    = cnt_q;
    opcode_d = opcode_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    miim_d   = miim_q;
    req_d    = 1'b0;
    done_d   = 2'b00;
    rd_d     = 32'h0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // An MIIM request waits here while the MDIO engine is busy and is
        // re-arbitrated every cycle until it can be issued.
        if (rq_valid != 2'b00 && (!pick_miim || mac_host_miim_rdy)) begin
          gnt_d    = pick;
          prio_d   = ~pick;
          opcode_d = pick_opcode;
          addr_d   = pick_addr;
          wdata_d  = pick_wdata;
          miim_d   = pick_miim;
          req_d    = 1'b1;
          state_d  = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d = 16'h0;
        if (miim_q) begin
          state_d = MIIM_LO;
        end else if (opcode_q[1]) begin
          state_d = CFG_WAIT;
        end else begin
          done_d  = done_vec;
          state_d = DONE;
        end
      end

      CFG_WAIT: begin
        if (cnt_q == CFG_LAST) begin
          rd_d    = mac_host_rd_data;
          done_d  = done_vec;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      MIIM_LO: begin
        cnt_d = cnt_inc;
        if (timeout_hit) begin
          rd_d    = TMO_RD_DATA;
          err_d   = 1'b1;
          done_d  = done_vec;
          state_d = DONE;
        end else if (!mac_host_miim_rdy) begin
          state_d = MIIM_HI;
        end
      end

      MIIM_HI: begin
        cnt_d = cnt_inc;
        // A genuine completion wins over a timeout landing on the same cycle.
        if (mac_host_miim_rdy) begin
          rd_d    = opcode_q[1] ? mac_host_rd_data : 32'h0;
          done_d  = done_vec;
          state_d = DONE;
        end else if (timeout_hit) begin
          rd_d    = TMO_RD_DATA;
          err_d   = 1'b1;
          done_d  = done_vec;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grant, counter and all registered outputs
  always_ff @(posedge mac_host_clk or posedge mac_host_reset) begin
    if (mac_host_reset) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      prio_q   <= 1'b0;
      cnt_q    <= 16'h0;
      opcode_q <= 2'b00;
      addr_q   <= 10'h0;
      wdata_q  <= 32'h0;
      miim_q   <= 1'b0;
      req_q    <= 1'b0;
      done_q   <= 2'b00;
      rd_q     <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      prio_q   <= prio_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      miim_q   <= miim_d;
      req_q    <= req_d;
      done_q   <= done_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

  assign rq_done           = done_q;
  assign rq_rd_data        = rd_q;
  assign rq_err            = err_q;
  assign mac_host_opcode   = opcode_q;
  assign mac_host_addr     = addr_q;
  assign mac_host_wr_data  = wdata_q;
  assign mac_host_miim_sel = miim_q;
  assign mac_host_req      = req_q;

`ifdef MAC_HOST_CFG_STATS_EN
  logic [15:0] stat_xact_q, stat_xact_d;
  logic [15:0] stat_tmo_q, stat_tmo_d;

  // Saturating completion and timeout counts, advanced once per DONE cycle
  always_comb begin
    stat_xact_d = stat_xact_q;
    stat_tmo_d  = stat_tmo_q;
    if (state_q == DONE) begin
      if (stat_xact_q != 16'hFFFF) stat_xact_d = stat_xact_q + 16'd1;
      if (err_q && stat_tmo_q != 16'hFFFF) stat_tmo_d = stat_tmo_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge mac_host_clk or posedge mac_host_reset) begin
    if (mac_host_reset) begin
      stat_xact_q <= 16'h0;
      stat_tmo_q  <= 16'h0;
    end else begin
      stat_xact_q <= stat_xact_d;
      stat_tmo_q  <= stat_tmo_d;
    end
  end

  assign stat_xact_cnt    = stat_xact_q;
  assign stat_timeout_cnt = stat_tmo_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
